// File: rtl/router_fsm_nch_if.sv
// Control/status bundle between the 1xN router datapath and its control FSM.
// slave = FSM side, master = datapath/source side.
interface router_fsm_nch_if #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 8
);
    logic              pkt_valid;
    logic [ADDR_W-1:0] data_in;
    logic              fifo_full;
    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] soft_reset;
    logic              parity_done;
    logic              low_pkt_valid;

    logic              detect_add;
    logic              lfd_state;
    logic              ld_state;
    logic              laf_state;
    logic              full_state;
    logic              write_enb_reg;
    logic              rst_int_reg;
    logic              busy;
    logic              drop_state;
    logic [ADDR_W-1:0] cur_addr;
    logic [CNT_W-1:0]  drop_count;

    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset, parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg,
               rst_int_reg, busy, drop_state, cur_addr, drop_count
    );

    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset, parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg,
               rst_int_reg, busy, drop_state, cur_addr, drop_count
    );
endinterface

// File: rtl/router_fsm_nch.sv
// 1xN router control FSM: header decode, load sequencing, full stalls,
// wait-till-empty with timeout, invalid-address drop and per-channel soft reset.
module router_fsm_nch #(
    parameter int NUM_CH  = 3,
    parameter int ADDR_W  = 2,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic            clock,
    input  logic            resetn,
    router_fsm_nch_if.slave bus
);
    typedef enum logic [3:0] {
        DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL,
        LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY, DROP_PACKET
    } state_e;

    localparam int NA     = 1 << ADDR_W;
    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e            state, nxt;
    logic [ADDR_W-1:0] cur_addr;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  drop_cnt;
    logic [NA-1:0]     empty_ext, soft_ext;
    logic              addr_ok, wait_clr, wait_inc, drop_inc;

    // Zero-extend per-channel flags so any address value indexes safely.
    assign empty_ext = NA'(bus.fifo_empty);
    assign soft_ext  = NA'(bus.soft_reset);
    assign addr_ok   = ({1'b0, bus.data_in} < (ADDR_W + 1)'(NUM_CH));

    always_comb begin
        nxt      = state;
        wait_clr = 1'b0;
        wait_inc = 1'b0;
        drop_inc = 1'b0;
        case (state)
            DECODE_ADDRESS:
                if (bus.pkt_valid) begin
                    if (!addr_ok) begin
                        nxt      = DROP_PACKET;
                        drop_inc = 1'b1;
                    end else if (empty_ext[bus.data_in]) begin
                        nxt = LOAD_FIRST_DATA;
                    end else begin
                        nxt      = WAIT_TILL_EMPTY;
                        wait_clr = 1'b1;
                    end
                end
            LOAD_FIRST_DATA: nxt = LOAD_DATA;
            LOAD_DATA:
                if (bus.fifo_full)       nxt = FIFO_FULL_STATE;
                else if (!bus.pkt_valid) nxt = LOAD_PARITY;
            FIFO_FULL_STATE:
                if (!bus.fifo_full) nxt = LOAD_AFTER_FULL;
            LOAD_AFTER_FULL:
                if (bus.parity_done)        nxt = DECODE_ADDRESS;
                else if (bus.low_pkt_valid) nxt = LOAD_PARITY;
                else                        nxt = LOAD_DATA;
            LOAD_PARITY: nxt = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR:
                nxt = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            WAIT_TILL_EMPTY:
                if (empty_ext[cur_addr]) begin
                    nxt = LOAD_FIRST_DATA;
                end else if (TIMEOUT != 0 && wait_cnt == WAIT_LAST) begin
                    nxt      = DROP_PACKET;
                    drop_inc = 1'b1;
                end else begin
                    wait_inc = 1'b1;
                end
            DROP_PACKET:
                if (!bus.pkt_valid) nxt = DECODE_ADDRESS;
            default: nxt = DECODE_ADDRESS;
        endcase

        // Soft reset of the addressed channel aborts the packet from any active state.
        if (state != DECODE_ADDRESS && state != DROP_PACKET && soft_ext[cur_addr]) begin
            nxt      = DECODE_ADDRESS;
            wait_inc = 1'b0;
            drop_inc = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= DECODE_ADDRESS;
            cur_addr <= '0;
            wait_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            state <= nxt;
            if (state == DECODE_ADDRESS && bus.pkt_valid) cur_addr <= bus.data_in;
            if (wait_clr)      wait_cnt <= '0;
            else if (wait_inc) wait_cnt <= wait_cnt + 1'b1;
            if (drop_inc && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign bus.detect_add    = (state == DECODE_ADDRESS);
    assign bus.lfd_state     = (state == LOAD_FIRST_DATA);
    assign bus.ld_state      = (state == LOAD_DATA);
    assign bus.laf_state     = (state == LOAD_AFTER_FULL);
    assign bus.full_state    = (state == FIFO_FULL_STATE);
    assign bus.rst_int_reg   = (state == CHECK_PARITY_ERROR);
    assign bus.drop_state    = (state == DROP_PACKET);
    assign bus.write_enb_reg = (state inside {LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL});
    assign bus.busy          = (state inside {LOAD_FIRST_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL,
                                              LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY});
    assign bus.cur_addr      = cur_addr;
    assign bus.drop_count    = drop_cnt;
endmodule

// File: tb/tb_router_fsm_nch.sv
// Bench for router_fsm_nch: two instances (long timeout / wide counter and short
// timeout / 2-bit counter) share one stimulus stream and a packet-level model.
module tb_router_fsm_nch;
    typedef enum {S_DEC, S_LFD, S_LD, S_LAF, S_FULL, S_LP, S_CPE, S_WAIT, S_DROP} s_e;
    typedef struct { s_e st; int addr; int wcnt; int drop; } mdl_t;
    typedef struct { bit pv; bit full; bit low; bit pd; bit [2:0] sr; s_e exp; } st_t;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       pkt_valid = 1'b0, fifo_full = 1'b0, parity_done = 1'b0, low_pkt_valid = 1'b0;
    logic [1:0] data_in = 2'd0;
    logic [2:0] fifo_empty = 3'b111, soft_reset = 3'b000;
    int         errors = 0, checks = 0;
    mdl_t       ma, mb;

    always #5 clock = ~clock;

    router_fsm_nch_if #(.NUM_CH(3), .ADDR_W(2), .CNT_W(8)) ifa ();
    router_fsm_nch_if #(.NUM_CH(3), .ADDR_W(2), .CNT_W(2)) ifb ();

    assign ifa.pkt_valid = pkt_valid;     assign ifb.pkt_valid = pkt_valid;
    assign ifa.data_in = data_in;         assign ifb.data_in = data_in;
    assign ifa.fifo_full = fifo_full;     assign ifb.fifo_full = fifo_full;
    assign ifa.fifo_empty = fifo_empty;   assign ifb.fifo_empty = fifo_empty;
    assign ifa.soft_reset = soft_reset;   assign ifb.soft_reset = soft_reset;
    assign ifa.parity_done = parity_done; assign ifb.parity_done = parity_done;
    assign ifa.low_pkt_valid = low_pkt_valid; assign ifb.low_pkt_valid = low_pkt_valid;

    router_fsm_nch #(.NUM_CH(3), .ADDR_W(2), .TIMEOUT(8), .CNT_W(8)) dut_a (
        .clock(clock), .resetn(resetn), .bus(ifa));
    router_fsm_nch #(.NUM_CH(3), .ADDR_W(2), .TIMEOUT(4), .CNT_W(2)) dut_b (
        .clock(clock), .resetn(resetn), .bus(ifb));

    wire [8:0] obs_a = {ifa.detect_add, ifa.lfd_state, ifa.ld_state, ifa.laf_state, ifa.full_state,
                        ifa.write_enb_reg, ifa.rst_int_reg, ifa.busy, ifa.drop_state};
    wire [8:0] obs_b = {ifb.detect_add, ifb.lfd_state, ifb.ld_state, ifb.laf_state, ifb.full_state,
                        ifb.write_enb_reg, ifb.rst_int_reg, ifb.busy, ifb.drop_state};

    // Expected {detect,lfd,ld,laf,full,wen,rst_int,busy,drop} for a named phase.
    function automatic logic [8:0] flags(s_e s);
        case (s)
            S_DEC:   return 9'b100000000;
            S_LFD:   return 9'b010000010;
            S_LD:    return 9'b001001000;
            S_LAF:   return 9'b000101010;
            S_FULL:  return 9'b000010010;
            S_LP:    return 9'b000001010;
            S_CPE:   return 9'b000000110;
            S_WAIT:  return 9'b000000010;
            default: return 9'b000000001;
        endcase
    endfunction

    // Packet-level reference: what the router should do next given this cycle's inputs.
    function automatic mdl_t mstep(mdl_t m, int to, int dmax);
        mdl_t n = m;
        case (m.st)
            S_DEC: if (pkt_valid) begin
                n.addr = int'(data_in);
                if (n.addr >= 3) begin n.st = S_DROP; n.drop = (m.drop < dmax) ? m.drop + 1 : dmax; end
                else if (fifo_empty[n.addr]) n.st = S_LFD;
                else begin n.st = S_WAIT; n.wcnt = 0; end
            end
            S_LFD:  n.st = S_LD;
            S_LD:   if (fifo_full) n.st = S_FULL; else if (!pkt_valid) n.st = S_LP;
            S_FULL: if (!fifo_full) n.st = S_LAF;
            S_LAF:  n.st = parity_done ? S_DEC : (low_pkt_valid ? S_LP : S_LD);
            S_LP:   n.st = S_CPE;
            S_CPE:  n.st = fifo_full ? S_FULL : S_DEC;
            S_WAIT: if (fifo_empty[m.addr]) n.st = S_LFD;
                    else if (m.wcnt + 1 == to) begin
                        n.st = S_DROP; n.drop = (m.drop < dmax) ? m.drop + 1 : dmax;
                    end else n.wcnt = m.wcnt + 1;
            default: if (!pkt_valid) n.st = S_DEC;
        endcase
        if (m.st != S_DEC && m.st != S_DROP && m.addr < 3 && soft_reset[m.addr]) begin
            n.st = S_DEC; n.drop = m.drop;
        end
        return n;
    endfunction

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ma <= '{S_DEC, 0, 0, 0};
            mb <= '{S_DEC, 0, 0, 0};
        end else begin
            ma <= mstep(ma, 8, 255);
            mb <= mstep(mb, 4, 3);
        end
    end

    task automatic tick;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle;
        pkt_valid = 0; fifo_full = 0; parity_done = 0; low_pkt_valid = 0;
        data_in = 0; fifo_empty = 3'b111; soft_reset = 0;
    endtask

    task automatic do_reset;
        idle();
        @(negedge clock);
        resetn = 0;
        tick();
        resetn = 1;
    endtask

    task automatic test_reset;
        idle();
        @(negedge clock);
        resetn = 0;
        #1;
        checks += 4;
        if (obs_a !== 9'b100000000) begin errors++; $display("FAIL reset_flags_a got=%b exp=100000000", obs_a); end
        if (obs_b !== 9'b100000000) begin errors++; $display("FAIL reset_flags_b got=%b exp=100000000", obs_b); end
        if (ifa.cur_addr !== 2'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", ifa.cur_addr); end
        if (ifa.drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop got=%0d exp=0", ifa.drop_count); end
        tick();
        resetn = 1;
    endtask

    task automatic test_normal;
        st_t seq [6] = '{'{1,0,0,0,0,S_LFD}, '{1,0,0,0,0,S_LD}, '{1,0,0,0,0,S_LD},
                         '{0,0,0,0,0,S_LP},  '{0,0,0,0,0,S_CPE}, '{0,0,0,0,0,S_DEC}};
        int wen = 0, rsti = 0;
        do_reset();
        data_in = 2; fifo_empty = 3'b100;
        foreach (seq[i]) begin
            pkt_valid = seq[i].pv;
            tick();
            checks++;
            if (obs_a !== flags(seq[i].exp))
                begin errors++; $display("FAIL normal_step%0d got=%b exp=%b", i, obs_a, flags(seq[i].exp)); end
            wen += int'(ifa.write_enb_reg);
            rsti += int'(ifa.rst_int_reg);
        end
        checks += 3;
        if (ifa.cur_addr !== 2'd2) begin errors++; $display("FAIL normal_addr got=%0d exp=2", ifa.cur_addr); end
        if (wen != 3) begin errors++; $display("FAIL normal_wen_cycles got=%0d exp=3", wen); end
        if (rsti != 1) begin errors++; $display("FAIL normal_rst_int_cycles got=%0d exp=1", rsti); end
    endtask

    task automatic test_full_stall;
        st_t seq [21] = '{
            '{1,0,0,0,0,S_LFD}, '{1,0,0,0,0,S_LD},  '{1,1,0,0,0,S_FULL}, '{1,1,0,0,0,S_FULL},
            '{1,0,1,0,0,S_LAF}, '{0,0,1,0,0,S_LP},  '{0,0,0,0,0,S_CPE},  '{0,0,0,0,0,S_DEC},
            '{1,0,0,0,0,S_LFD}, '{1,0,0,0,0,S_LD},  '{1,1,0,0,0,S_FULL}, '{1,0,0,0,0,S_LAF},
            '{1,0,0,0,0,S_LD},  '{0,0,0,0,0,S_LP},  '{0,0,0,0,0,S_CPE},  '{0,0,0,0,0,S_DEC},
            '{1,0,0,0,0,S_LFD}, '{1,0,0,0,0,S_LD},  '{1,1,0,0,0,S_FULL}, '{0,0,0,0,0,S_LAF},
            '{0,0,0,1,0,S_DEC}};
        do_reset();
        data_in = 0; fifo_empty = 3'b111;
        foreach (seq[i]) begin
            pkt_valid = seq[i].pv; fifo_full = seq[i].full;
            low_pkt_valid = seq[i].low; parity_done = seq[i].pd;
            tick();
            checks++;
            if (obs_a !== flags(seq[i].exp))
                begin errors++; $display("FAIL full_step%0d got=%b exp=%b", i, obs_a, flags(seq[i].exp)); end
        end
    endtask

    task automatic test_wait_then_load;
        do_reset();
        data_in = 1; fifo_empty = 3'b101; pkt_valid = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (obs_a !== flags(S_WAIT)) begin errors++; $display("FAIL wait_cycle%0d got=%b exp=%b", i, obs_a, flags(S_WAIT)); end
        end
        fifo_empty = 3'b111;
        tick();
        checks += 2;
        if (obs_a !== flags(S_LFD)) begin errors++; $display("FAIL wait_to_lfd got=%b exp=%b", obs_a, flags(S_LFD)); end
        if (ifa.drop_count !== 8'd0) begin errors++; $display("FAIL wait_drop got=%0d exp=0", ifa.drop_count); end
    endtask

    task automatic test_timeout;
        do_reset();
        data_in = 0; fifo_empty = 3'b110; pkt_valid = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs_b !== flags(S_WAIT)) begin errors++; $display("FAIL tmo_wait%0d got=%b exp=%b", i, obs_b, flags(S_WAIT)); end
        end
        tick();
        checks += 3;
        if (obs_b !== flags(S_DROP)) begin errors++; $display("FAIL tmo_drop got=%b exp=%b", obs_b, flags(S_DROP)); end
        if (ifb.drop_count !== 2'd1) begin errors++; $display("FAIL tmo_count got=%0d exp=1", ifb.drop_count); end
        if (ifb.busy !== 1'b0) begin errors++; $display("FAIL tmo_busy got=%b exp=0", ifb.busy); end
        pkt_valid = 0;
        tick();
        checks++;
        if (obs_b !== flags(S_DEC)) begin errors++; $display("FAIL tmo_back got=%b exp=%b", obs_b, flags(S_DEC)); end
    endtask

    task automatic test_invalid_addr;
        do_reset();
        data_in = 3;
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 3; c++) begin
                pkt_valid = (c < 2);
                tick();
                checks++;
                if (obs_a !== flags(c < 2 ? S_DROP : S_DEC))
                    begin errors++; $display("FAIL inv_drop%0d_%0d got=%b exp=%b", k, c, obs_a, flags(c < 2 ? S_DROP : S_DEC)); end
            end
            if (k == 0) begin
                checks++;
                if (ifa.drop_count !== 8'd1) begin errors++; $display("FAIL inv_first got=%0d exp=1", ifa.drop_count); end
            end
        end
        checks += 2;
        if (ifa.drop_count !== 8'd5) begin errors++; $display("FAIL inv_count_a got=%0d exp=5", ifa.drop_count); end
        if (ifb.drop_count !== 2'd3) begin errors++; $display("FAIL inv_sat_b got=%0d exp=3", ifb.drop_count); end
    endtask

    task automatic test_soft_reset;
        st_t seq [4] = '{'{1,0,0,0,3'b000,S_LFD}, '{1,0,0,0,3'b000,S_LD},
                         '{1,0,0,0,3'b001,S_LD},  '{1,0,0,0,3'b010,S_DEC}};
        do_reset();
        data_in = 1; fifo_empty = 3'b111;
        foreach (seq[i]) begin
            pkt_valid = seq[i].pv; soft_reset = seq[i].sr;
            tick();
            checks++;
            if (obs_a !== flags(seq[i].exp))
                begin errors++; $display("FAIL soft_step%0d got=%b exp=%b", i, obs_a, flags(seq[i].exp)); end
        end
        soft_reset = 0; pkt_valid = 0;
        checks++;
        if (ifa.cur_addr !== 2'd1) begin errors++; $display("FAIL soft_addr got=%0d exp=1", ifa.cur_addr); end
    endtask

    task automatic test_async_reset;
        do_reset();
        data_in = 3; pkt_valid = 1; tick();
        pkt_valid = 0; tick();
        data_in = 0; pkt_valid = 1; tick(); tick();
        fifo_full = 1; tick();
        checks += 2;
        if (obs_a !== flags(S_FULL)) begin errors++; $display("FAIL async_pre got=%b exp=%b", obs_a, flags(S_FULL)); end
        if (ifa.drop_count !== 8'd1) begin errors++; $display("FAIL async_pre_drop got=%0d exp=1", ifa.drop_count); end
        #2 resetn = 0;
        #1;
        checks += 3;
        if (ifa.detect_add !== 1'b1) begin errors++; $display("FAIL async_detect got=%b exp=1", ifa.detect_add); end
        if (obs_a !== 9'b100000000) begin errors++; $display("FAIL async_flags got=%b exp=100000000", obs_a); end
        if (ifa.drop_count !== 8'd0) begin errors++; $display("FAIL async_drop got=%0d exp=0", ifa.drop_count); end
        idle();
        @(negedge clock);
        resetn = 1;
    endtask

    task automatic test_random;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            pkt_valid = ($urandom_range(0, 3) != 0);
            data_in = 2'($urandom_range(0, 3));
            fifo_full = ($urandom_range(0, 3) == 0);
            fifo_empty = 3'($urandom);
            parity_done = ($urandom_range(0, 3) == 0);
            low_pkt_valid = ($urandom_range(0, 2) == 0);
            soft_reset = ($urandom_range(0, 19) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'b000;
            tick();
            checks += 6;
            if (obs_a !== flags(ma.st)) begin errors++; $display("FAIL rnd_a_flags cyc=%0d got=%b exp=%b", i, obs_a, flags(ma.st)); end
            if (obs_b !== flags(mb.st)) begin errors++; $display("FAIL rnd_b_flags cyc=%0d got=%b exp=%b", i, obs_b, flags(mb.st)); end
            if (int'(ifa.cur_addr) !== ma.addr) begin errors++; $display("FAIL rnd_a_addr cyc=%0d got=%0d exp=%0d", i, ifa.cur_addr, ma.addr); end
            if (int'(ifb.cur_addr) !== mb.addr) begin errors++; $display("FAIL rnd_b_addr cyc=%0d got=%0d exp=%0d", i, ifb.cur_addr, mb.addr); end
            if (int'(ifa.drop_count) !== ma.drop) begin errors++; $display("FAIL rnd_a_drop cyc=%0d got=%0d exp=%0d", i, ifa.drop_count, ma.drop); end
            if (int'(ifb.drop_count) !== mb.drop) begin errors++; $display("FAIL rnd_b_drop cyc=%0d got=%0d exp=%0d", i, ifb.drop_count, mb.drop); end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_full_stall();
        test_wait_then_load();
        test_timeout();
        test_invalid_addr();
        test_soft_reset();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/router_fsm_nch.md
Name: router_fsm_nch

Overview:
Parametrised control FSM for the 1xN router, the successor to the fixed 1x3 router FSM. It decodes the header address and sequences the header, payload and parity loads into the addressed FIFO. It also handles FIFO-full stalls, parity-check timing, per-channel soft reset, invalid-address packet drop and a wait-till-empty timeout. It sits between the input register/synchroniser stage and the N output FIFOs.

Parameters:
NUM_CH, 3, number of output channels; legal range 2..2**ADDR_W.
ADDR_W, 2, width of the header address field (data_in).
TIMEOUT, 64, maximum cycles spent in WAIT_TILL_EMPTY before the packet is dropped; 0 disables the timeout.
CNT_W, 8, width of the saturating dropped-packet counter.

Ports:
clock  in  1  system clock, rising edge.
resetn  in  1  asynchronous active-low reset.
pkt_valid  in  1  source byte valid; high for header and payload, low for the parity byte.
data_in  in  ADDR_W  header address bits (header byte [ADDR_W-1:0]).
fifo_full  in  1  full flag of the currently addressed FIFO (muxed by the synchroniser).
fifo_empty  in  NUM_CH  per-channel FIFO empty flags.
soft_reset  in  NUM_CH  per-channel soft reset from the output timeouts.
parity_done  in  1  parity byte has been loaded.
low_pkt_valid  in  1  pkt_valid fell while the FSM was stalled on full.
detect_add  out  1  state == DECODE_ADDRESS.
lfd_state  out  1  state == LOAD_FIRST_DATA.
ld_state  out  1  state == LOAD_DATA.
laf_state  out  1  state == LOAD_AFTER_FULL.
full_state  out  1  state == FIFO_FULL_STATE.
write_enb_reg  out  1  write enable to the register stage.
rst_int_reg  out  1  state == CHECK_PARITY_ERROR.
busy  out  1  stalls the source.
drop_state  out  1  state == DROP_PACKET.
cur_addr  out  ADDR_W  latched destination address.
drop_count  out  CNT_W  number of packets dropped, saturating.

Behaviour:
- Reset (resetn low, asynchronous):
  - state = DECODE_ADDRESS, cur_addr = 0, wait counter = 0, drop_count = 0.
  - Outputs at reset: detect_add=1; every other state output, write_enb_reg, rst_int_reg and busy = 0.
  - Reset takes effect immediately regardless of state, including mid-packet.
- Address latch: cur_addr is loaded from data_in on any clock edge where state==DECODE_ADDRESS and pkt_valid=1. It holds otherwise.
- Address legality: "valid" means data_in < NUM_CH.
- State transitions (next state registered; outputs are a Moore decode of the current state):
  - DECODE_ADDRESS:
    - pkt_valid & valid & fifo_empty[data_in] -> LOAD_FIRST_DATA.
    - pkt_valid & valid & !fifo_empty[data_in] -> WAIT_TILL_EMPTY (wait counter cleared).
    - pkt_valid & !valid -> DROP_PACKET (drop_count += 1, saturating at all ones).
    - Otherwise stay.
  - LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
  - LOAD_DATA:
    - fifo_full -> FIFO_FULL_STATE.
    - else !pkt_valid -> LOAD_PARITY.
    - else stay.
  - FIFO_FULL_STATE: fifo_full -> stay; else -> LOAD_AFTER_FULL.
  - LOAD_AFTER_FULL:
    - parity_done -> DECODE_ADDRESS.
    - else low_pkt_valid -> LOAD_PARITY.
    - else -> LOAD_DATA.
  - LOAD_PARITY -> CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
  - WAIT_TILL_EMPTY:
    - fifo_empty[cur_addr] -> LOAD_FIRST_DATA (empty has priority over timeout in the same cycle).
    - else if TIMEOUT != 0 and wait counter == TIMEOUT-1 -> DROP_PACKET (drop_count += 1).
    - else stay, wait counter += 1.
  - DROP_PACKET: pkt_valid -> stay; else -> DECODE_ADDRESS. The parity byte that follows is ignored in DECODE_ADDRESS because pkt_valid=0.
- Soft reset: soft_reset[cur_addr] high in any state except DECODE_ADDRESS and DROP_PACKET forces next state = DECODE_ADDRESS. It overrides all other transitions. Soft resets of non-addressed channels are ignored.
- write_enb_reg = 1 in LOAD_DATA, LOAD_PARITY and LOAD_AFTER_FULL.
- busy = 1 in LOAD_FIRST_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR and WAIT_TILL_EMPTY.
- busy = 0 in DECODE_ADDRESS, LOAD_DATA and DROP_PACKET; DROP_PACKET consumes and discards bytes at full rate.
- Any unused state encoding -> DECODE_ADDRESS.

Test Plan:
- Normal packet, NUM_CH=3: reset; header addr=2, fifo_empty=3'b100, pkt_valid high 3 cycles then low.
  - Required sequence: DECODE -> LFD -> LD,LD -> LOAD_PARITY -> CHECK_PARITY_ERROR -> DECODE.
  - Required outputs: cur_addr=2; write_enb_reg high 3 cycles; rst_int_reg high 1 cycle.
- Full stall: in LOAD_DATA assert fifo_full for 2 cycles, then parity_done=0, low_pkt_valid=1.
  - Required sequence: FULL, FULL, LAF, LOAD_PARITY, CHECK_PARITY_ERROR, DECODE.
  - Required outputs: busy high throughout. Repeat with low_pkt_valid=0 -> LAF returns to LD.
- Wait then load: header addr=1 with fifo_empty[1]=0 for 5 cycles, then 1.
  - Required sequence: WAIT_TILL_EMPTY for 5 cycles with busy=1, then LFD; drop_count stays 0.
- Timeout drop, TIMEOUT=4: header addr=0 with fifo_empty[0]=0 held.
  - Required sequence: after exactly 4 cycles in WAIT -> DROP_PACKET, drop_count=1, busy=0.
  - Drop pkt_valid -> DECODE next cycle.
- Invalid address: header addr=3 with NUM_CH=3.
  - Required: DROP_PACKET next cycle; drop_count increments; no write_enb_reg, lfd_state or busy throughout. With CNT_W=2, 5 drops leave drop_count=3.
- Soft reset and async reset mid-packet:
  - In LD with cur_addr=1, pulse soft_reset[0] -> no effect; pulse soft_reset[1] -> DECODE next cycle.
  - Pull resetn low between clock edges in FULL -> detect_add=1 immediately and drop_count=0.
